// File: rtl/seg7_capture.sv
// ============================================================================
// Module   : seg7_capture
// Purpose  : Reader for a multiplexed, active-low 7-segment bus. Samples the
//            segment lines {a..g} and a one-hot digit strobe, waits until a
//            pattern has been stable for STABLE_CYCLES samples, decodes it back
//            to a 4-bit code (0..9, 10 = dash, 11 = blank) and stores it in a
//            per-digit register file.
// Ports    : clock, reset (sync, active-high)
//            a..g        in  active-low segment lines, pat = {a,b,c,d,e,f,g}
//            digit_en    in  one-hot digit select (NUM_DIGITS bits)
//            numeros     out decoded codes, digit i at [4i+3:4i]
//            digit_valid out digit i written since reset
//            upd/upd_idx out one-cycle write pulse and the digit written
//            bad_pat     out one-cycle pulse: stable pattern with no decode
//            multi_en    out one-cycle pulse: >1 digit_en bit was sampled
// Options  : SEG7_CAP_CHANGE_ONLY_EN - when defined, an accept that rewrites
//            an already valid digit with the same code does not pulse upd.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int IDX_W         = 2,
  parameter int STABLE_CYCLES = 3,
  parameter int CNT_W         = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    a,
  input  logic                    b,
  input  logic                    c,
  input  logic                    d,
  input  logic                    e,
  input  logic                    f,
  input  logic                    g,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [4*NUM_DIGITS-1:0] numeros,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    upd,
  output logic [IDX_W-1:0]        upd_idx,
  output logic                    bad_pat,
  output logic                    multi_en
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);

  // Returns {legal, code}; legal=0 for any pattern outside the table.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'b0000001: r = {1'b1, 4'd0};
      7'b1001111: r = {1'b1, 4'd1};
      7'b0010010: r = {1'b1, 4'd2};
      7'b0000110: r = {1'b1, 4'd3};
      7'b1001100: r = {1'b1, 4'd4};
      7'b0100100: r = {1'b1, 4'd5};
      7'b0100000: r = {1'b1, 4'd6};
      7'b0001101: r = {1'b1, 4'd7};
      7'b0000000: r = {1'b1, 4'd8};
      7'b0000100: r = {1'b1, 4'd9};
      7'b1111110: r = {1'b1, 4'd10};
      7'b1111111: r = {1'b1, 4'd11};
      default:    r = 5'b0_0000;
    endcase
    return r;
  endfunction

  state_t                  state_q, state_d;
  logic [6:0]              s_pat_q, s_pat_d;
  logic [NUM_DIGITS-1:0]   s_en_q, s_en_d;
  logic [6:0]              cur_pat_q, cur_pat_d;
  logic [IDX_W-1:0]        cur_idx_q, cur_idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] numeros_q, numeros_d;
  logic [NUM_DIGITS-1:0]   digit_valid_q, digit_valid_d;
  logic                    upd_q, upd_d;
  logic [IDX_W-1:0]        upd_idx_q, upd_idx_d;
  logic                    bad_pat_q, bad_pat_d;
  logic                    multi_en_q, multi_en_d;

  logic                    en_onehot;
  logic [IDX_W-1:0]        en_idx;
  logic                    do_check;
  logic [4:0]              dec;

  always_comb begin
    s_pat_d       = {a, b, c, d, e, f, g};
    s_en_d        = digit_en;
    state_d       = state_q;
    cur_pat_d     = cur_pat_q;
    cur_idx_d     = cur_idx_q;
    cnt_d         = cnt_q;
    numeros_d     = numeros_q;
    digit_valid_d = digit_valid_q;
    upd_d         = 1'b0;
    upd_idx_d     = upd_idx_q;
    bad_pat_d     = 1'b0;
    multi_en_d    = ($countones(s_en_q) >= 2);
    do_check      = 1'b0;
    dec           = 5'b0_0000;

    en_onehot = $onehot(s_en_q);
    en_idx    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (s_en_q[i]) en_idx = IDX_W'(i);
    end

    case (state_q)
      IDLE: begin
        if (en_onehot) begin
          state_d   = TRACK;
          cur_pat_d = s_pat_q;
          cur_idx_d = en_idx;
          cnt_d     = CNT_W'(1);
          do_check  = 1'b1;
        end
      end
      TRACK: begin
        if (!en_onehot) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if ((s_pat_q != cur_pat_q) || (en_idx != cur_idx_q)) begin
          // pattern and/or digit change restart the count as one event
          cur_pat_d = s_pat_q;
          cur_idx_d = en_idx;
          cnt_d     = CNT_W'(1);
          do_check  = 1'b1;
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
          do_check = 1'b1;
        end
      end
      LOCKED: begin
        // counter is frozen here so a long hold can never wrap and re-accept
        if (en_onehot && (s_pat_q == cur_pat_q) && (en_idx == cur_idx_q)) begin
          state_d = LOCKED;
        end else if (en_onehot) begin
          state_d   = TRACK;
          cur_pat_d = s_pat_q;
          cur_idx_d = en_idx;
          cnt_d     = CNT_W'(1);
          do_check  = 1'b1;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Accept on the same edge the count reaches the threshold, which also
    // covers STABLE_CYCLES=1 accepting directly on TRACK entry.
    if (do_check && (cnt_d == STABLE_C)) begin
      state_d = LOCKED;
      dec     = decode(cur_pat_d);
      if (dec[4]) begin
`ifdef SEG7_CAP_CHANGE_ONLY_EN
        upd_d = !(digit_valid_q[cur_idx_d] &&
                  (numeros_q[{cur_idx_d, 2'b00} +: 4] == dec[3:0]));
`else
        upd_d = 1'b1;
`endif
        numeros_d[{cur_idx_d, 2'b00} +: 4] = dec[3:0];
        digit_valid_d[cur_idx_d]            = 1'b1;
        upd_idx_d                           = cur_idx_d;
      end else begin
        bad_pat_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      s_pat_q       <= '0;
      s_en_q        <= '0;
      cur_pat_q     <= '0;
      cur_idx_q     <= '0;
      cnt_q         <= '0;
      numeros_q     <= '0;
      digit_valid_q <= '0;
      upd_q         <= 1'b0;
      upd_idx_q     <= '0;
      bad_pat_q     <= 1'b0;
      multi_en_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      s_pat_q       <= s_pat_d;
      s_en_q        <= s_en_d;
      cur_pat_q     <= cur_pat_d;
      cur_idx_q     <= cur_idx_d;
      cnt_q         <= cnt_d;
      numeros_q     <= numeros_d;
      digit_valid_q <= digit_valid_d;
      upd_q         <= upd_d;
      upd_idx_q     <= upd_idx_d;
      bad_pat_q     <= bad_pat_d;
      multi_en_q    <= multi_en_d;
    end
  end

  assign numeros     = numeros_q;
  assign digit_valid = digit_valid_q;
  assign upd         = upd_q;
  assign upd_idx     = upd_idx_q;
  assign bad_pat     = bad_pat_q;
  assign multi_en    = multi_en_q;

endmodule

`default_nettype wire
